// File: rtl/fixed_point_pkg.sv
// Shared mode encodings and parameter sanity check for the fixed-point sign operator.
package fixed_point_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ABS  = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_NABS = 2'b11;

    function automatic bit params_ok(input int width, input int frac_bits, input int num_ch);
        return (frac_bits >= 0) && (frac_bits < width) && (num_ch >= 1);
    endfunction

endpackage

// File: rtl/fixed_point_neg_sat.sv
// One lane of the sign operator: combinational (x, mode) -> (y, sat).
module fixed_point_neg_sat
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic [WIDTH-1:0] x_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] y_o,
    output logic             sat_o
);

    logic [WIDTH-1:0] min_code;
    logic [WIDTH-1:0] neg_x;
    logic             is_neg;
    logic             is_pos;
    logic             do_neg;

    always_comb begin
        min_code           = '0;
        min_code[WIDTH-1]  = 1'b1;
        is_neg             = x_i[WIDTH-1];
        is_pos             = !x_i[WIDTH-1] && (x_i != '0);
        neg_x              = '0 - x_i;
        do_neg             = 1'b0;
        case (mode_i)
            MODE_PASS: do_neg = 1'b0;
            MODE_ABS:  do_neg = is_neg;
            MODE_NEG:  do_neg = 1'b1;
            MODE_NABS: do_neg = is_pos;
            default:   do_neg = 1'b0;
        endcase

        y_o   = x_i;
        sat_o = 1'b0;
        // Only the most-negative code has no representable negation; clamp to MAX.
        if (do_neg) begin
            if (x_i == min_code) begin
                y_o   = ~min_code;
                sat_o = 1'b1;
            end else begin
                y_o = neg_x;
            end
        end
    end

endmodule

// File: rtl/fixed_point_abs_vec.sv
// Multi-lane saturating sign operator behind a 2-stage valid/ready pipeline,
// with a sticky saturation flag updated on delivered beats.
module fixed_point_abs_vec
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 3,
    parameter int NUM_CH    = 4
)(
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic [NUM_CH*WIDTH-1:0] VALUE_IN,
    input  logic [1:0]              MODE_IN,
    input  logic                    VALID_IN,
    output logic                    READY_IN,
    output logic [NUM_CH*WIDTH-1:0] VALUE_OUT,
    output logic [NUM_CH-1:0]       SAT_OUT,
    output logic                    VALID_OUT,
    input  logic                    READY_OUT,
    output logic                    SAT_STICKY,
    input  logic                    CLEAR_SAT
);

    if (!params_ok(WIDTH, FRAC_BITS, NUM_CH)) begin : g_param_check
        $error("fixed_point_abs_vec: need 0 <= FRAC_BITS < WIDTH and NUM_CH >= 1");
    end

    logic                    v1_q;
    logic [NUM_CH*WIDTH-1:0] val1_q;
    logic [1:0]              mode1_q;
    logic                    v2_q;
    logic [NUM_CH*WIDTH-1:0] res2_q;
    logic [NUM_CH-1:0]       sat2_q;
    logic                    sticky_q;

    logic [NUM_CH*WIDTH-1:0] res_d;
    logic [NUM_CH-1:0]       sat_d;
    logic                    sticky_d;
    logic                    rdy1;
    logic                    rdy2;

    assign rdy2     = !v2_q || READY_OUT;
    assign rdy1     = !v1_q || rdy2;
    assign READY_IN = rdy1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        fixed_point_neg_sat #(
            .WIDTH (WIDTH)
        ) u_lane (
            .x_i    (val1_q[i*WIDTH +: WIDTH]),
            .mode_i (mode1_q),
            .y_o    (res_d[i*WIDTH +: WIDTH]),
            .sat_o  (sat_d[i])
        );
    end

    // A clear wins over a same-cycle set, dropping that beat's saturation.
    always_comb begin
        sticky_d = sticky_q;
        if (CLEAR_SAT) begin
            sticky_d = 1'b0;
        end else if (v2_q && READY_OUT && (|sat2_q)) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            v1_q     <= 1'b0;
            val1_q   <= '0;
            mode1_q  <= MODE_PASS;
            v2_q     <= 1'b0;
            res2_q   <= '0;
            sat2_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (rdy1) begin
                v1_q <= VALID_IN;
            end
            if (rdy1 && VALID_IN) begin
                val1_q  <= VALUE_IN;
                mode1_q <= MODE_IN;
            end
            if (rdy2) begin
                v2_q <= v1_q;
            end
            if (rdy2 && v1_q) begin
                res2_q <= res_d;
                sat2_q <= sat_d;
            end
            sticky_q <= sticky_d;
        end
    end

    assign VALUE_OUT  = res2_q;
    assign SAT_OUT    = sat2_q;
    assign VALID_OUT  = v2_q;
    assign SAT_STICKY = sticky_q;

endmodule

// File: tb/tb_fixed_point_abs_vec.sv
// Randomized and directed bench for fixed_point_abs_vec against an integer reference model.
module tb_fixed_point_abs_vec;

    localparam int W  = 8;
    localparam int NC = 4;
    localparam int W2 = 16;

    typedef struct packed {
        logic [NC*W-1:0] val;
        logic [NC-1:0]   sat;
    } beat_t;

    typedef struct packed {
        logic [W2-1:0] val;
        logic          sat;
    } beat2_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [NC*W-1:0] value_in;
    logic [1:0]      mode_in;
    logic            valid_in;
    logic            ready_in;
    logic [NC*W-1:0] value_out;
    logic [NC-1:0]   sat_out;
    logic            valid_out;
    logic            ready_out;
    logic            sat_sticky;
    logic            clear_sat;

    logic [W2-1:0]   value_in2;
    logic [1:0]      mode_in2;
    logic            valid_in2;
    logic            ready_in2;
    logic [W2-1:0]   value_out2;
    logic [0:0]      sat_out2;
    logic            valid_out2;
    logic            ready_out2;
    logic            sat_sticky2;
    logic            clear_sat2;

    fixed_point_abs_vec #(.WIDTH(W), .FRAC_BITS(3), .NUM_CH(NC)) u_dut (
        .CLK        (clk),
        .RSTN       (rstn),
        .VALUE_IN   (value_in),
        .MODE_IN    (mode_in),
        .VALID_IN   (valid_in),
        .READY_IN   (ready_in),
        .VALUE_OUT  (value_out),
        .SAT_OUT    (sat_out),
        .VALID_OUT  (valid_out),
        .READY_OUT  (ready_out),
        .SAT_STICKY (sat_sticky),
        .CLEAR_SAT  (clear_sat)
    );

    fixed_point_abs_vec #(.WIDTH(W2), .FRAC_BITS(8), .NUM_CH(1)) u_dut16 (
        .CLK        (clk),
        .RSTN       (rstn),
        .VALUE_IN   (value_in2),
        .MODE_IN    (mode_in2),
        .VALID_IN   (valid_in2),
        .READY_IN   (ready_in2),
        .VALUE_OUT  (value_out2),
        .SAT_OUT    (sat_out2),
        .VALID_OUT  (valid_out2),
        .READY_OUT  (ready_out2),
        .SAT_STICKY (sat_sticky2),
        .CLEAR_SAT  (clear_sat2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: interpret as signed integer, apply the rule, clamp to MAX.
    function automatic void ref_lane(input int w, input logic [31:0] xb, input logic [1:0] m,
                                     output logic [31:0] y, output logic sat);
        longint mask, maxv, x, r;
        mask = (longint'(1) << w) - 1;
        maxv = (longint'(1) << (w - 1)) - 1;
        x    = longint'(xb) & mask;
        if (x > maxv) x = x - (mask + 1);
        case (m)
            2'b00:   r = x;
            2'b01:   r = (x < 0) ? -x : x;
            2'b10:   r = -x;
            default: r = (x > 0) ? -x : x;
        endcase
        sat = (r > maxv);
        if (sat) r = maxv;
        y = 32'(r & mask);
    endfunction

    function automatic beat_t ref_beat(input logic [NC*W-1:0] v, input logic [1:0] m);
        beat_t       b;
        logic [31:0] ly;
        logic        ls;
        for (int i = 0; i < NC; i++) begin
            ref_lane(W, {24'b0, v[i*W +: W]}, m, ly, ls);
            b.val[i*W +: W] = ly[W-1:0];
            b.sat[i]        = ls;
        end
        return b;
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            4:       return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            4:       return 16'h8001;
            default: return 16'($urandom);
        endcase
    endfunction

    beat_t           exp_q[$];
    beat2_t          exp2_q[$];
    logic            sticky_m   = 1'b0;
    bit              armed      = 1'b0;
    bit              prev_stall = 1'b0;
    logic [NC*W-1:0] prev_val;
    logic [NC-1:0]   prev_sat;
    int              n_out      = 0;
    int              n_out2     = 0;

    always @(negedge clk) begin
        beat_t e;
        logic  deliver_sat;
        deliver_sat = 1'b0;
        if (armed) check("sticky", 64'(sat_sticky), 64'(sticky_m));
        if (prev_stall) begin
            check("stall_valid", 64'(valid_out), 64'd1);
            check("stall_value", 64'(value_out), 64'(prev_val));
            check("stall_sat", 64'(sat_out), 64'(prev_sat));
        end
        if (!rstn) begin
            exp_q.delete();
            sticky_m   = 1'b0;
            armed      = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (valid_out && ready_out) begin
                n_out++;
                check("out_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("value", 64'(value_out), 64'(e.val));
                    check("sat", 64'(sat_out), 64'(e.sat));
                    deliver_sat = |e.sat;
                end
            end
            if (valid_in && ready_in) exp_q.push_back(ref_beat(value_in, mode_in));
            if (clear_sat) sticky_m = 1'b0;
            else if (deliver_sat) sticky_m = 1'b1;
            prev_stall = valid_out && !ready_out;
            prev_val   = value_out;
            prev_sat   = sat_out;
        end
    end

    always @(negedge clk) begin
        beat2_t      e;
        logic [31:0] ly;
        logic        ls;
        if (!rstn) begin
            exp2_q.delete();
        end else begin
            if (valid_out2 && ready_out2) begin
                n_out2++;
                check("w16_out_expected", 64'(exp2_q.size() > 0), 64'd1);
                if (exp2_q.size() > 0) begin
                    e = exp2_q.pop_front();
                    check("w16_value", 64'(value_out2), 64'(e.val));
                    check("w16_sat", 64'(sat_out2), 64'(e.sat));
                end
            end
            if (valid_in2 && ready_in2) begin
                ref_lane(W2, {16'b0, value_in2}, mode_in2, ly, ls);
                e.val = ly[W2-1:0];
                e.sat = ls;
                exp2_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NC*W-1:0] v, input logic [1:0] m);
        int g;
        g        = 0;
        valid_in = 1'b1;
        value_in = v;
        mode_in  = m;
        #1;
        while (!ready_in && g < 50) begin
            step();
            g++;
        end
        check("send_ready", 64'(ready_in), 64'd1);
        step();
        valid_in = 1'b0;
        value_in = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int              base;
        int              sent;
        int              g;
        bit              saw_drop;
        bit              pend;
        bit              pend2;
        logic [NC*W-1:0] vals [8];

        rstn       = 1'b0;
        value_in   = '0;
        mode_in    = 2'b00;
        valid_in   = 1'b0;
        ready_out  = 1'b1;
        clear_sat  = 1'b0;
        value_in2  = '0;
        mode_in2   = 2'b00;
        valid_in2  = 1'b0;
        ready_out2 = 1'b1;
        clear_sat2 = 1'b0;
        repeat (3) step();

        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_value_out", 64'(value_out), 64'd0);
        check("rst_sat_out", 64'(sat_out), 64'd0);
        check("rst_sticky", 64'(sat_sticky), 64'd0);
        check("rst_w16_valid", 64'(valid_out2), 64'd0);
        rstn = 1'b1;
        #1;
        check("rst_ready_in", 64'(ready_in), 64'd1);

        // abs: result visible once the beat has passed both registers
        send(32'hFF00_08F8, 2'b01);
        check("t1_stage1_only", 64'(valid_out), 64'd0);
        step();
        check("t1_valid", 64'(valid_out), 64'd1);
        check("t1_value", 64'(value_out), 64'h0100_0808);
        check("t1_sat", 64'(sat_out), 64'd0);
        step();

        // neg with most-negative lane
        send(32'h7F7F_7F80, 2'b10);
        step();
        check("t2_value", 64'(value_out), 64'h8181_817F);
        check("t2_sat", 64'(sat_out), 64'h1);
        repeat (2) step();
        check("t2_sticky_set", 64'(sat_sticky), 64'd1);
        clear_sat = 1'b1;
        step();
        clear_sat = 1'b0;
        check("t2_sticky_clr", 64'(sat_sticky), 64'd0);

        // 8-beat stream with downstream stall in cycles 3..6
        for (int i = 0; i < 8; i++) vals[i] = {pick8(), pick8(), pick8(), pick8()};
        base     = n_out;
        sent     = 0;
        saw_drop = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ready_out = !(c >= 3 && c <= 6);
            valid_in  = (sent < 8);
            if (sent < 8) begin
                value_in = vals[sent];
                mode_in  = (sent % 2 == 1) ? 2'b01 : 2'b10;
            end
            #1;
            if (!ready_in) saw_drop = 1'b1;
            if (valid_in && ready_in) sent++;
            step();
        end
        valid_in = 1'b0;
        check("t3_ready_dropped", 64'(saw_drop), 64'd1);
        check("t3_outputs", 64'(n_out - base), 64'd8);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // neg-abs never saturates
        ready_out = 1'b1;
        send(32'h0080_FB05, 2'b11);
        step();
        check("t4_value", 64'(value_out), 64'h0080_FBFB);
        check("t4_sat", 64'(sat_out), 64'd0);
        step();

        // reset with two beats in flight
        send(32'h0000_0080, 2'b10);
        repeat (3) step();
        check("t5_sticky_pre", 64'(sat_sticky), 64'd1);
        ready_out = 1'b0;
        send({pick8(), pick8(), pick8(), pick8()}, 2'b00);
        send(32'h8080_8080, 2'b10);
        check("t5_full", 64'(ready_in), 64'd0);
        base = n_out;
        rstn = 1'b0;
        step();
        rstn      = 1'b1;
        ready_out = 1'b1;
        check("t5_valid_out", 64'(valid_out), 64'd0);
        check("t5_sticky", 64'(sat_sticky), 64'd0);
        repeat (10) step();
        check("t5_no_emit", 64'(n_out - base), 64'd0);

        // clear coincides with a saturating delivery
        ready_out = 1'b0;
        send(32'h0000_8000, 2'b10);
        g = 0;
        while (!valid_out && g < 10) begin
            step();
            g++;
        end
        check("t6_reached_out", 64'(valid_out), 64'd1);
        clear_sat = 1'b1;
        ready_out = 1'b1;
        step();
        clear_sat = 1'b0;
        check("t6_sticky", 64'(sat_sticky), 64'd0);
        step();
        check("t6_sticky_hold", 64'(sat_sticky), 64'd0);

        // randomized sweep, 4x8
        pend = 1'b0;
        repeat (300) begin
            ready_out = ($urandom_range(0, 3) != 0);
            clear_sat = ($urandom_range(0, 15) == 0);
            if (!pend) begin
                value_in = {pick8(), pick8(), pick8(), pick8()};
                mode_in  = 2'($urandom);
                pend     = ($urandom_range(0, 3) != 0);
            end
            valid_in = pend;
            #1;
            if (valid_in && ready_in) pend = 1'b0;
            step();
        end
        valid_in  = 1'b0;
        clear_sat = 1'b0;
        ready_out = 1'b1;
        repeat (5) step();
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // randomized sweep, 1x16
        base  = n_out2;
        pend2 = 1'b0;
        repeat (300) begin
            ready_out2 = ($urandom_range(0, 3) != 0);
            if (!pend2) begin
                value_in2 = pick16();
                mode_in2  = 2'($urandom);
                pend2     = ($urandom_range(0, 3) != 0);
            end
            valid_in2 = pend2;
            #1;
            if (valid_in2 && ready_in2) pend2 = 1'b0;
            step();
        end
        valid_in2  = 1'b0;
        ready_out2 = 1'b1;
        repeat (5) step();
        check("w16_drained", 64'(exp2_q.size()), 64'd0);
        check("w16_activity", 64'(n_out2 - base > 50), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
